// File: rtl/uart_pkt_pkg.sv
// Shared UART packet definitions: type codes, INFO address range, channel index.
// Used by both the host bridge and the on-chip packet mux.
package uart_pkt_pkg;

    localparam logic [7:0] PARROT          = 8'd0;
    localparam logic [7:0] ETH_FRAME_IN    = 8'd1;
    localparam logic [7:0] ETH_FRAME_OUT   = 8'd2;
    localparam logic [7:0] REMAINING_LAYER = 8'd3;
    localparam logic [7:0] INSTRUCTION     = 8'd4;
    localparam logic [7:0] BRAIN_STATUS    = 8'd5;
    localparam logic [7:0] PAYLOAD_COMING  = 8'd6;
    localparam logic [7:0] INFO            = 8'd7;

    localparam logic [7:0]  INFO_ADDR_FIRST = 8'd0;
    localparam logic [7:0]  INFO_ADDR_LAST  = 8'd27;
    localparam int unsigned INFO_ADDR_COUNT = 28;

    // Declaration order is the round-robin order.
    typedef enum logic [1:0] {
        ChInstr   = 2'd0,
        ChEth     = 2'd1,
        ChPayload = 2'd2,
        ChInfo    = 2'd3
    } chan_e;

    typedef enum logic [1:0] {
        TIdle = 2'd0,
        THdr  = 2'd1,
        TAddr = 2'd2,
        TData = 2'd3
    } tx_state_e;

    typedef enum logic {
        RHdr  = 1'b0,
        RData = 1'b1
    } rx_state_e;

    function automatic logic [7:0] chan_type(chan_e ch);
        logic [7:0] code;
        code = INSTRUCTION;
        unique case (ch)
            ChInstr:   code = INSTRUCTION;
            ChEth:     code = ETH_FRAME_IN;
            ChPayload: code = PAYLOAD_COMING;
            ChInfo:    code = INFO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_host_rr_arb.sv
// 4-way round-robin arbiter; the winner is captured on latch and the priority
// pointer moves past it on advance.
module uart_host_rr_arb
    import uart_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       latch,
    input  logic       advance,
    output logic       any_req,
    output chan_e      grant
);

    chan_e      ptr_q;
    chan_e      grant_q;
    chan_e      winner;
    logic [1:0] idx;

    // Scan from the farthest offset down so the closest requester to ptr_q wins.
    always_comb begin
        winner = ptr_q;
        idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                winner = chan_e'(idx);
            end
        end
    end

    assign any_req = |req;
    assign grant   = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= ChInstr;
            grant_q <= ChInstr;
        end else begin
            if (latch) begin
                grant_q <= winner;
            end
            if (advance) begin
                ptr_q <= chan_e'(grant_q + 2'd1);
            end
        end
    end

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side UART packet encoder/decoder. Define UART_HOST_BRIDGE_STATS_EN to add
// saturating packet counters.
module uart_host_bridge
    import uart_pkt_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [7:0]  instr_tdata,
    input  logic        instr_tvalid,
    output logic        instr_tready,
    input  logic        instr_tlast,

    input  logic [7:0]  eth_tdata,
    input  logic        eth_tvalid,
    output logic        eth_tready,
    input  logic        eth_tlast,

    input  logic [7:0]  payload_tdata,
    input  logic        payload_tvalid,
    output logic        payload_tready,
    input  logic        payload_tlast,

    input  logic [15:0] info_tdata,
    input  logic        info_tvalid,
    output logic        info_tready,
    input  logic        info_tlast,

    output logic [7:0]  uart_tx_tdata,
    output logic        uart_tx_tvalid,
    input  logic        uart_tx_tready,
    output logic        uart_tx_tlast,

    input  logic [7:0]  uart_rx_tdata,
    input  logic        uart_rx_tvalid,
    output logic        uart_rx_tready,
    input  logic        uart_rx_tlast,

    output logic [7:0]  echo_tdata,
    output logic        echo_tvalid,
    input  logic        echo_tready,
    output logic        echo_tlast,

    output logic [7:0]  frame_out_tdata,
    output logic        frame_out_tvalid,
    input  logic        frame_out_tready,
    output logic        frame_out_tlast,

    output logic [7:0]  layer_tdata,
    output logic        layer_tvalid,
    input  logic        layer_tready,
    output logic        layer_tlast,

    output logic [7:0]  status_tdata,
    output logic        status_tvalid,
    input  logic        status_tready,
    output logic        status_tlast
`ifdef UART_HOST_BRIDGE_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] tx_pkt_count,
    output logic [COUNT_WIDTH-1:0] rx_pkt_count,
    output logic [COUNT_WIDTH-1:0] rx_drop_count
`endif
);

    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;
    logic [7:0] hdr_q, hdr_d;

    logic  arb_any;
    logic  arb_latch;
    logic  arb_advance;
    chan_e grant;
    logic  tx_done;
    logic  rx_known_hs;
    logic  rx_drop_hs;

    assign uart_tx_tlast   = 1'b0;
    assign echo_tlast      = 1'b0;
    assign frame_out_tlast = 1'b0;
    assign layer_tlast     = 1'b0;
    assign status_tlast    = 1'b0;

    logic unused_tlast;
    assign unused_tlast = instr_tlast ^ eth_tlast ^ payload_tlast ^ info_tlast ^ uart_rx_tlast;

    uart_host_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({info_tvalid, payload_tvalid, eth_tvalid, instr_tvalid}),
        .latch   (arb_latch),
        .advance (arb_advance),
        .any_req (arb_any),
        .grant   (grant)
    );

    // TX encoder; all outputs held low while rst is asserted.
    always_comb begin
        tx_state_d     = tx_state_q;
        uart_tx_tvalid = 1'b0;
        uart_tx_tdata  = 8'h00;
        instr_tready   = 1'b0;
        eth_tready     = 1'b0;
        payload_tready = 1'b0;
        info_tready    = 1'b0;
        arb_latch      = 1'b0;
        arb_advance    = 1'b0;
        tx_done        = 1'b0;
        if (!rst) begin
            unique case (tx_state_q)
                TIdle: begin
                    if (arb_any) begin
                        arb_latch  = 1'b1;
                        tx_state_d = THdr;
                    end
                end
                THdr: begin
                    uart_tx_tvalid = 1'b1;
                    uart_tx_tdata  = chan_type(grant);
                    if (uart_tx_tready) begin
                        tx_state_d = (grant == ChInfo) ? TAddr : TData;
                    end
                end
                TAddr: begin
                    uart_tx_tvalid = 1'b1;
                    uart_tx_tdata  = info_tdata[15:8];
                    if (uart_tx_tready) begin
                        tx_state_d = TData;
                    end
                end
                TData: begin
                    uart_tx_tvalid = 1'b1;
                    unique case (grant)
                        ChInstr: begin
                            uart_tx_tdata = instr_tdata;
                            instr_tready  = uart_tx_tready;
                        end
                        ChEth: begin
                            uart_tx_tdata = eth_tdata;
                            eth_tready    = uart_tx_tready;
                        end
                        ChPayload: begin
                            uart_tx_tdata  = payload_tdata;
                            payload_tready = uart_tx_tready;
                        end
                        ChInfo: begin
                            uart_tx_tdata = info_tdata[7:0];
                            info_tready   = uart_tx_tready;
                        end
                    endcase
                    if (uart_tx_tready) begin
                        arb_advance = 1'b1;
                        tx_done     = 1'b1;
                        tx_state_d  = TIdle;
                    end
                end
            endcase
        end
    end

    // RX decoder; data bytes pass straight through to the selected output.
    always_comb begin
        rx_state_d       = rx_state_q;
        hdr_d            = hdr_q;
        uart_rx_tready   = 1'b0;
        echo_tdata       = 8'h00;
        echo_tvalid      = 1'b0;
        frame_out_tdata  = 8'h00;
        frame_out_tvalid = 1'b0;
        layer_tdata      = 8'h00;
        layer_tvalid     = 1'b0;
        status_tdata     = 8'h00;
        status_tvalid    = 1'b0;
        rx_known_hs      = 1'b0;
        rx_drop_hs       = 1'b0;
        if (!rst) begin
            unique case (rx_state_q)
                RHdr: begin
                    uart_rx_tready = 1'b1;
                    if (uart_rx_tvalid) begin
                        hdr_d      = uart_rx_tdata;
                        rx_state_d = RData;
                    end
                end
                RData: begin
                    case (hdr_q)
                        PARROT: begin
                            echo_tdata     = uart_rx_tdata;
                            echo_tvalid    = uart_rx_tvalid;
                            uart_rx_tready = echo_tready;
                        end
                        ETH_FRAME_OUT: begin
                            frame_out_tdata  = uart_rx_tdata;
                            frame_out_tvalid = uart_rx_tvalid;
                            uart_rx_tready   = frame_out_tready;
                        end
                        REMAINING_LAYER: begin
                            layer_tdata    = uart_rx_tdata;
                            layer_tvalid   = uart_rx_tvalid;
                            uart_rx_tready = layer_tready;
                        end
                        BRAIN_STATUS: begin
                            status_tdata   = uart_rx_tdata;
                            status_tvalid  = uart_rx_tvalid;
                            uart_rx_tready = status_tready;
                        end
                        default: begin
                            uart_rx_tready = 1'b1;
                        end
                    endcase
                    if (uart_rx_tvalid && uart_rx_tready) begin
                        rx_state_d = RHdr;
                        case (hdr_q)
                            PARROT, ETH_FRAME_OUT, REMAINING_LAYER, BRAIN_STATUS: begin
                                rx_known_hs = 1'b1;
                            end
                            default: begin
                                rx_drop_hs = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TIdle;
            rx_state_q <= RHdr;
            hdr_q      <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            hdr_q      <= hdr_d;
        end
    end

`ifdef UART_HOST_BRIDGE_STATS_EN
    localparam logic [COUNT_WIDTH-1:0] CntMax = '1;

    logic [COUNT_WIDTH-1:0] tx_cnt_q;
    logic [COUNT_WIDTH-1:0] rx_cnt_q;
    logic [COUNT_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (tx_done && tx_cnt_q != CntMax) begin
                tx_cnt_q <= tx_cnt_q + COUNT_WIDTH'(1);
            end
            if (rx_known_hs && rx_cnt_q != CntMax) begin
                rx_cnt_q <= rx_cnt_q + COUNT_WIDTH'(1);
            end
            if (rx_drop_hs && drop_cnt_q != CntMax) begin
                drop_cnt_q <= drop_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign tx_pkt_count  = tx_cnt_q;
    assign rx_pkt_count  = rx_cnt_q;
    assign rx_drop_count = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = (^COUNT_WIDTH) ^ tx_done ^ rx_known_hs ^ rx_drop_hs;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed self-checking bench for uart_host_bridge: TX encoding, round-robin,
// RX demux/drop/backpressure and mid-packet reset.
module tb_uart_host_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  instr_tdata, eth_tdata, payload_tdata;
    logic        instr_tvalid, eth_tvalid, payload_tvalid, info_tvalid;
    logic        instr_tready, eth_tready, payload_tready, info_tready;
    logic [15:0] info_tdata;
    logic [7:0]  uart_tx_tdata;
    logic        uart_tx_tvalid, uart_tx_tready, uart_tx_tlast;
    logic [7:0]  uart_rx_tdata;
    logic        uart_rx_tvalid, uart_rx_tready;
    logic [7:0]  echo_tdata, frame_out_tdata, layer_tdata, status_tdata;
    logic        echo_tvalid, frame_out_tvalid, layer_tvalid, status_tvalid;
    logic        echo_tready, frame_out_tready, layer_tready, status_tready;
    logic        echo_tlast, frame_out_tlast, layer_tlast, status_tlast;
`ifdef UART_HOST_BRIDGE_STATS_EN
    logic [15:0] tx_pkt_count, rx_pkt_count, rx_drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int instr_rdy_cnt = 0;
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    uart_host_bridge #(.COUNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_tdata      (instr_tdata),
        .instr_tvalid     (instr_tvalid),
        .instr_tready     (instr_tready),
        .instr_tlast      (1'b0),
        .eth_tdata        (eth_tdata),
        .eth_tvalid       (eth_tvalid),
        .eth_tready       (eth_tready),
        .eth_tlast        (1'b0),
        .payload_tdata    (payload_tdata),
        .payload_tvalid   (payload_tvalid),
        .payload_tready   (payload_tready),
        .payload_tlast    (1'b0),
        .info_tdata       (info_tdata),
        .info_tvalid      (info_tvalid),
        .info_tready      (info_tready),
        .info_tlast       (1'b0),
        .uart_tx_tdata    (uart_tx_tdata),
        .uart_tx_tvalid   (uart_tx_tvalid),
        .uart_tx_tready   (uart_tx_tready),
        .uart_tx_tlast    (uart_tx_tlast),
        .uart_rx_tdata    (uart_rx_tdata),
        .uart_rx_tvalid   (uart_rx_tvalid),
        .uart_rx_tready   (uart_rx_tready),
        .uart_rx_tlast    (1'b0),
        .echo_tdata       (echo_tdata),
        .echo_tvalid      (echo_tvalid),
        .echo_tready      (echo_tready),
        .echo_tlast       (echo_tlast),
        .frame_out_tdata  (frame_out_tdata),
        .frame_out_tvalid (frame_out_tvalid),
        .frame_out_tready (frame_out_tready),
        .frame_out_tlast  (frame_out_tlast),
        .layer_tdata      (layer_tdata),
        .layer_tvalid     (layer_tvalid),
        .layer_tready     (layer_tready),
        .layer_tlast      (layer_tlast),
        .status_tdata     (status_tdata),
        .status_tvalid    (status_tvalid),
        .status_tready    (status_tready),
        .status_tlast     (status_tlast)
`ifdef UART_HOST_BRIDGE_STATS_EN
        ,
        .tx_pkt_count     (tx_pkt_count),
        .rx_pkt_count     (rx_pkt_count),
        .rx_drop_count    (rx_drop_count)
`endif
    );

    // Mid-cycle monitor: records accepted TX bytes and instr_tready pulses.
    always @(negedge clk) begin
        if (uart_tx_tvalid && uart_tx_tready) tx_q.push_back(uart_tx_tdata);
        if (instr_tready) instr_rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rr_exp [10];
        rr_exp = '{8'h04, 8'h11, 8'h01, 8'h22, 8'h06, 8'h33, 8'h07, 8'h1B, 8'h44, 8'h04};

        rst = 1'b1;
        instr_tdata = 8'h00; eth_tdata = 8'h00; payload_tdata = 8'h00; info_tdata = 16'h0000;
        instr_tvalid = 1'b0; eth_tvalid = 1'b0; payload_tvalid = 1'b0; info_tvalid = 1'b0;
        uart_tx_tready = 1'b1;
        uart_rx_tdata = 8'h00; uart_rx_tvalid = 1'b0;
        echo_tready = 1'b1; frame_out_tready = 1'b1; layer_tready = 1'b1; status_tready = 1'b1;

        // Reset state
        step(); step();
        #1;
        check("rst_tx_tvalid", uart_tx_tvalid, 1'b0);
        check("rst_tx_tdata", uart_tx_tdata, 8'h00);
        check("rst_rx_tready", uart_rx_tready, 1'b0);
        check("rst_instr_tready", instr_tready, 1'b0);
        check("rst_info_tready", info_tready, 1'b0);
        check("rst_echo_tvalid", echo_tvalid, 1'b0);
        check("rst_status_tvalid", status_tvalid, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_rx_tready", uart_rx_tready, 1'b1);

        // Single instruction packet
        step();
        tx_q.delete();
        instr_rdy_cnt = 0;
        instr_tvalid = 1'b1;
        instr_tdata  = 8'hA5;
        for (int k = 0; k < 10 && instr_rdy_cnt == 0; k++) step();
        instr_tvalid = 1'b0;
        step(); step(); step();
        check("instr_tready_pulses", instr_rdy_cnt, 1);
        check("instr_byte_count", tx_q.size(), 2);
        if (tx_q.size() >= 2) begin
            check("instr_hdr", tx_q[0], 8'h04);
            check("instr_data", tx_q[1], 8'hA5);
        end

        // INFO packet with toggling backpressure
        step();
        info_tvalid = 1'b1; info_tdata = 16'h0C7F; uart_tx_tready = 1'b0;
        #1; check("info_idle_tvalid", uart_tx_tvalid, 1'b0);
        step(); #1;
        check("info_hdr_stall_v", uart_tx_tvalid, 1'b1);
        check("info_hdr_stall_d", uart_tx_tdata, 8'h07);
        step(); uart_tx_tready = 1'b1; #1;
        check("info_hdr_go_d", uart_tx_tdata, 8'h07);
        step(); uart_tx_tready = 1'b0; #1;
        check("info_addr_stall_d", uart_tx_tdata, 8'h0C);
        step(); uart_tx_tready = 1'b1; #1;
        check("info_addr_go_d", uart_tx_tdata, 8'h0C);
        step(); uart_tx_tready = 1'b0; #1;
        check("info_data_stall_d", uart_tx_tdata, 8'h7F);
        check("info_data_stall_rdy", info_tready, 1'b0);
        step(); uart_tx_tready = 1'b1; #1;
        check("info_data_go_d", uart_tx_tdata, 8'h7F);
        check("info_data_go_rdy", info_tready, 1'b1);
        step(); info_tvalid = 1'b0; #1;
        check("info_done_tvalid", uart_tx_tvalid, 1'b0);

        // Round-robin with all four sources valid
        tx_q.delete();
        instr_tdata = 8'h11; eth_tdata = 8'h22; payload_tdata = 8'h33; info_tdata = 16'h1B44;
        instr_tvalid = 1'b1; eth_tvalid = 1'b1; payload_tvalid = 1'b1; info_tvalid = 1'b1;
        for (int k = 0; k < 60 && tx_q.size() < 10; k++) step();
        check("rr_enough_bytes", 32'(tx_q.size() >= 10), 1);
        for (int i = 0; i < 10; i++) begin
            if (i < tx_q.size()) check($sformatf("rr_byte%0d", i), tx_q[i], rr_exp[i]);
        end
        instr_tvalid = 1'b0; eth_tvalid = 1'b0; payload_tvalid = 1'b0; info_tvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Reset while in T_ADDR, address beyond the INFO range passes unchanged
        info_tvalid = 1'b1; info_tdata = 16'h2A99; uart_tx_tready = 1'b1;
        #1; check("rst_taddr_idle", uart_tx_tvalid, 1'b0);
        step(); #1;
        check("rst_taddr_hdr", uart_tx_tdata, 8'h07);
        step(); uart_tx_tready = 1'b0; #1;
        check("rst_taddr_in_addr_v", uart_tx_tvalid, 1'b1);
        check("rst_taddr_in_addr_d", uart_tx_tdata, 8'h2A);
        rst = 1'b1; info_tvalid = 1'b0;
        step(); rst = 1'b0; #1;
        check("rst_taddr_after_v", uart_tx_tvalid, 1'b0);
        tx_q.delete();
        eth_tvalid = 1'b1; eth_tdata = 8'h5A; uart_tx_tready = 1'b1;
        for (int k = 0; k < 10 && tx_q.size() < 2; k++) step();
        eth_tvalid = 1'b0;
        check("post_rst_bytes", tx_q.size(), 2);
        if (tx_q.size() >= 2) begin
            check("post_rst_hdr", tx_q[0], 8'h01);
            check("post_rst_data", tx_q[1], 8'h5A);
        end
`ifdef UART_HOST_BRIDGE_STATS_EN
        check("stats_tx_pkt", tx_pkt_count, 16'd1);
`endif

        // RX: unknown header dropped, then ETH_FRAME_OUT
        step(); uart_rx_tvalid = 1'b1; uart_rx_tdata = 8'h09; #1;
        check("drop_hdr_rdy", uart_rx_tready, 1'b1);
        step(); uart_rx_tdata = 8'h11; #1;
        check("drop_data_rdy", uart_rx_tready, 1'b1);
        check("drop_frame_v", frame_out_tvalid, 1'b0);
        check("drop_echo_v", echo_tvalid, 1'b0);
        check("drop_layer_v", layer_tvalid, 1'b0);
        check("drop_status_v", status_tvalid, 1'b0);
        step(); uart_rx_tdata = 8'h02; #1;
        check("frame_hdr_rdy", uart_rx_tready, 1'b1);
        check("frame_hdr_v", frame_out_tvalid, 1'b0);
        step(); uart_rx_tdata = 8'h22; #1;
        check("frame_v", frame_out_tvalid, 1'b1);
        check("frame_d", frame_out_tdata, 8'h22);
        check("frame_rdy", uart_rx_tready, 1'b1);
        step(); uart_rx_tvalid = 1'b0; #1;
        check("frame_done_v", frame_out_tvalid, 1'b0);
`ifdef UART_HOST_BRIDGE_STATS_EN
        check("stats_rx_drop", rx_drop_count, 16'd1);
        check("stats_rx_pkt", rx_pkt_count, 16'd1);
`endif

        // RX: BRAIN_STATUS with 5 cycles of backpressure
        uart_rx_tvalid = 1'b1; uart_rx_tdata = 8'h05; status_tready = 1'b0; #1;
        check("status_hdr_rdy", uart_rx_tready, 1'b1);
        step(); uart_rx_tdata = 8'h3C; #1;
        check("status_v", status_tvalid, 1'b1);
        check("status_d", status_tdata, 8'h3C);
        check("status_stall0", uart_rx_tready, 1'b0);
        for (int k = 1; k < 5; k++) begin
            step(); #1;
            check($sformatf("status_stall%0d", k), uart_rx_tready, 1'b0);
            check($sformatf("status_hold%0d", k), status_tdata, 8'h3C);
        end
        step(); status_tready = 1'b1; #1;
        check("status_release_rdy", uart_rx_tready, 1'b1);
        step(); uart_rx_tvalid = 1'b0; #1;
        check("status_done_v", status_tvalid, 1'b0);
        check("status_done_rdy", uart_rx_tready, 1'b1);

        // RX: PARROT and REMAINING_LAYER routing
        uart_rx_tvalid = 1'b1; uart_rx_tdata = 8'h00;
        step(); uart_rx_tdata = 8'hAB; #1;
        check("echo_v", echo_tvalid, 1'b1);
        check("echo_d", echo_tdata, 8'hAB);
        check("echo_layer_v", layer_tvalid, 1'b0);
        step(); uart_rx_tdata = 8'h03;
        step(); uart_rx_tdata = 8'hCD; #1;
        check("layer_v", layer_tvalid, 1'b1);
        check("layer_d", layer_tdata, 8'hCD);
        check("layer_echo_v", echo_tvalid, 1'b0);
        step(); uart_rx_tvalid = 1'b0;

        check("tlast_tied", {uart_tx_tlast, echo_tlast, frame_out_tlast, layer_tlast,
                             status_tlast}, 5'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
